multi_vu_meter: RTL and testbench

MULTI_VU_METER -- requirements
Module: multi_vu_meter

---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_serial_master.sv | 91 +++++++++
 rtl/multi_vu_meter.sv | 152 +++++++++++++++
 tb/tb_multi_vu_meter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared ADC frame geometry and LED threshold helper for the VU meter slice.
package adc_pkg;

  // Serial frame geometry (in SCLK bits)
  localparam int unsigned FRAME_LEN      = 16;
  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned ADDR_FIRST_BIT = 2;
  localparam int unsigned ADDR_LAST_BIT  = ADDR_FIRST_BIT + ADDR_W - 1;
  localparam int unsigned DATA_START_BIT = 4;

  // Threshold for LED idx: ((idx+1) * 2^adc_bits) / (led_n+1), integer division
  function automatic int unsigned threshold(input int unsigned idx,
                                            input int unsigned adc_bits,
                                            input int unsigned led_n);
    return ((idx + 1) << adc_bits) / (led_n + 1);
  endfunction

endpackage

// File: rtl/adc_serial_master.sv
// Free-running serial ADC master: SCLK = clk/2, 16-bit frames, one-frame
// address/data pipeline, one sample_valid pulse per completed frame.
module adc_serial_master
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ADC_BITS = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sdat,
  output logic                saddr,
  output logic                sclk,
  output logic                cs_n,
  output logic [ADC_BITS-1:0] sample,
  output logic [ADDR_W-1:0]   sample_ch,
  output logic                sample_valid
);

  localparam int unsigned      BIT_W    = $clog2(FRAME_LEN);
  localparam int unsigned      AIDX_W   = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0] DATA_BIT = BIT_W'(DATA_START_BIT);
  localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_CH - 1);

  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    bit_next;
  logic [ADC_BITS-1:0] shreg;
  logic [ADC_BITS-1:0] shifted;
  logic [ADDR_W-1:0]   cur_ch;
  logic [ADDR_W-1:0]   prev_ch;
  logic [ADDR_W-1:0]   next_ch;
  logic                primed;
  logic                saddr_next;

  // Bit index that the coming SCLK falling edge starts, plus data shift value
  always_comb begin
    bit_next = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
    shifted  = {shreg[ADC_BITS-2:0], sdat};
    next_ch  = (cur_ch == LAST_CH) ? '0 : cur_ch + ADDR_W'(1);
  end

  // Address bit for the coming SCLK bit: channel MSB-first on the address slots
  always_comb begin
    saddr_next = 1'b0;
    for (int unsigned k = ADDR_FIRST_BIT; k <= ADDR_LAST_BIT; k++) begin
      if (bit_next == BIT_W'(k))
        saddr_next = cur_ch[AIDX_W'(ADDR_LAST_BIT - k)];
    end
  end

  // SCLK generation, frame sequencing, data capture and sample hand-off.
  // bit_cnt resets to the last bit so the first falling edge begins bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk         <= 1'b1;
      cs_n         <= 1'b1;
      saddr        <= 1'b0;
      bit_cnt      <= LAST_BIT;
      shreg        <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      primed       <= 1'b0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
    end else begin
      sclk         <= ~sclk;
      sample_valid <= 1'b0;
      if (sclk) begin
        // SCLK falling: start the next bit and present its address bit
        cs_n    <= 1'b0;
        bit_cnt <= bit_next;
        saddr   <= saddr_next;
      end else begin
        // SCLK rising: sample data bits, close the frame on the last bit
        if (bit_cnt >= DATA_BIT)
          shreg <= shifted;
        if (bit_cnt == LAST_BIT) begin
          sample       <= shifted;
          sample_ch    <= prev_ch;
          sample_valid <= primed;
          prev_ch      <= cur_ch;
          cur_ch       <= next_ch;
          primed       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_vu_meter.sv
// Multi-channel VU meter: round-robin ADC scan, per-channel windowed peak,
// decaying held peak and registered LED bar/dot display.
module multi_vu_meter
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ADC_BITS   = 12,
  parameter int unsigned LED_N      = 8,
  parameter int unsigned WIN_FRAMES = 256,
  parameter int unsigned DECAY_STEP = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adc_sdat,
  output logic             adc_saddr,
  output logic             adc_sclk,
  output logic             adc_cs_n,
  input  logic [2:0]       disp_ch,
  input  logic             dot_mode,
  output logic [LED_N-1:0] leds
);

  localparam int unsigned CW    = $clog2(LED_N + 1);
  localparam int unsigned CNT_W = $clog2(WIN_FRAMES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WIN_FRAMES - 1);
  localparam logic [ADC_BITS-1:0] DECAY    = ADC_BITS'(DECAY_STEP);

  logic [ADC_BITS-1:0] sample;
  logic [ADDR_W-1:0]   sample_ch;
  logic                sample_valid;

  logic [ADC_BITS-1:0] win_max [NUM_CH];
  logic [ADC_BITS-1:0] level   [NUM_CH];
  logic [ADC_BITS-1:0] held    [NUM_CH];
  logic [CNT_W-1:0]    cnt     [NUM_CH];

  logic [ADC_BITS-1:0] cur_max;
  logic [ADC_BITS-1:0] cur_held;
  logic [CNT_W-1:0]    cur_cnt;
  logic [ADC_BITS-1:0] new_max;
  logic [ADC_BITS-1:0] decayed;
  logic [ADC_BITS-1:0] held_next;
  logic                win_end;

  logic [ADDR_W-1:0]   disp_idx;
  logic [ADC_BITS-1:0] sel_level;
  logic [ADC_BITS-1:0] sel_held;
  logic [CW-1:0]       n_bar;
  logic [CW-1:0]       n_dot;
  logic [LED_N-1:0]    leds_next;

  adc_serial_master #(
    .NUM_CH   (NUM_CH),
    .ADC_BITS (ADC_BITS)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .sdat         (adc_sdat),
    .saddr        (adc_saddr),
    .sclk         (adc_sclk),
    .cs_n         (adc_cs_n),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid)
  );

  // Number of LEDs lit for value v (thresholds fold to constants)
  function automatic logic [CW-1:0] lit_count(input logic [ADC_BITS-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < LED_N; i++) begin
      if (32'(v) >= threshold(i, ADC_BITS, LED_N))
        n = n + CW'(1);
    end
    return n;
  endfunction

  // Fetch the addressed channel's state and compute its frame-end update
  always_comb begin
    cur_max  = '0;
    cur_held = '0;
    cur_cnt  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sample_ch == ADDR_W'(c)) begin
        cur_max  = win_max[c];
        cur_held = held[c];
        cur_cnt  = cnt[c];
      end
    end
    new_max   = (sample > cur_max) ? sample : cur_max;
    win_end   = (cur_cnt == CNT_LAST);
    decayed   = (cur_held > DECAY) ? cur_held - DECAY : '0;
    held_next = (new_max >= decayed) ? new_max : decayed;
  end

  // Per-channel running max, window counter, level latch and peak hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        win_max[c] <= '0;
        level[c]   <= '0;
        held[c]    <= '0;
        cnt[c]     <= '0;
      end
    end else if (sample_valid) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (sample_ch == ADDR_W'(c)) begin
          if (win_end) begin
            level[c]   <= new_max;
            held[c]    <= held_next;
            win_max[c] <= '0;
            cnt[c]     <= '0;
          end else begin
            win_max[c] <= new_max;
            cnt[c]     <= cur_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // Select the displayed channel (out-of-range requests fall back to 0)
  always_comb begin
    disp_idx  = (32'(disp_ch) < NUM_CH) ? ADDR_W'(disp_ch) : '0;
    sel_level = '0;
    sel_held  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (disp_idx == ADDR_W'(c)) begin
        sel_level = level[c];
        sel_held  = held[c];
      end
    end
  end

  // Bar from level, optional single dot at the held-peak position
  always_comb begin
    n_bar     = lit_count(sel_level);
    n_dot     = lit_count(sel_held);
    leds_next = '0;
    for (int unsigned i = 0; i < LED_N; i++)
      leds_next[i] = (CW'(i) < n_bar) || (dot_mode && (n_dot == CW'(i + 1)));
  end

  // Registered LED output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      leds <= '0;
    else
      leds <= leds_next;
  end

endmodule

// File: tb/tb_multi_vu_meter.sv
// Directed bench for multi_vu_meter with a behavioural serial ADC model.
module tb_multi_vu_meter;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       adc_sdat = 1'b0;
  logic       adc_saddr;
  logic       adc_sclk;
  logic       adc_cs_n;
  logic [2:0] disp_ch  = 3'd0;
  logic       dot_mode = 1'b0;
  logic [7:0] leds;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  logic [11:0] adc_val [8];

  // ADC model state and logs
  logic [3:0]  m_bit   = 4'hF;
  logic        m_first = 1'b1;
  logic [2:0]  m_addr  = 3'd0;
  logic [11:0] m_word  = 12'd0;
  int unsigned adr_n     = 0;
  int unsigned val_n     = 0;
  int unsigned bad_saddr = 0;
  logic [2:0]  adr_log  [8];
  logic [2:0]  vch_log  [8];
  logic [11:0] vdat_log [8];
  logic [7:0]  dot_exp  [9];

  multi_vu_meter #(
    .NUM_CH     (4),
    .ADC_BITS   (12),
    .LED_N      (8),
    .WIN_FRAMES (4),
    .DECAY_STEP (64)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_sdat  (adc_sdat),
    .adc_saddr (adc_saddr),
    .adc_sclk  (adc_sclk),
    .adc_cs_n  (adc_cs_n),
    .disp_ch   (disp_ch),
    .dot_mode  (dot_mode),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  // Serial ADC: returns the previous frame's addressed value, junk on frame 1
  always @(posedge clk) begin
    #1;
    if (adc_cs_n === 1'b1) begin
      m_bit    = 4'hF;
      m_first  = 1'b1;
      adc_sdat = 1'b0;
    end else if (adc_cs_n === 1'b0 && adc_sclk === 1'b0) begin
      m_bit = m_bit + 4'd1;
      if (m_bit == 4'd0) begin
        m_word  = m_first ? 12'hFFF : adc_val[m_addr];
        m_first = 1'b0;
      end
      case (m_bit)
        4'd2: m_addr[2] = adc_saddr;
        4'd3: m_addr[1] = adc_saddr;
        4'd4: begin
          m_addr[0] = adc_saddr;
          if (adr_n < 8) adr_log[adr_n] = m_addr;
          adr_n++;
        end
        default: if (adc_saddr !== 1'b0) bad_saddr++;
      endcase
      adc_sdat = (m_bit >= 4'd4) ? m_word[4'd15 - m_bit] : 1'b0;
    end
    if (u_dut.u_ser.sample_valid === 1'b1) begin
      if (val_n < 8) begin
        vch_log[val_n]  = u_dut.u_ser.sample_ch;
        vdat_log[val_n] = u_dut.u_ser.sample;
      end
      val_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to cycle n after reset release, then settle 1 time unit
  task automatic step_to(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    foreach (adc_val[i]) adc_val[i] = 12'd0;
    adc_val[1] = 12'hFFF;
    dot_exp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h40, 8'h40, 8'h40};
    disp_ch  = 3'd1;
    dot_mode = 1'b0;
    rst_n    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n",  32'(adc_cs_n),  32'h1);
    check("rst_sclk",  32'(adc_sclk),  32'h1);
    check("rst_saddr", 32'(adc_saddr), 32'h0);
    check("rst_leds",  32'(leds),      32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Five frames of addresses, four tagged samples (frame 1 discarded)
    step_to(165);
    check("addr_count", adr_n, 5);
    for (int unsigned k = 0; k < 5; k++)
      check($sformatf("addr_f%0d", k + 1), 32'(adr_log[k]), k % 4);
    check("valid_count", val_n, 4);
    for (int unsigned k = 0; k < 4; k++)
      check($sformatf("tag_v%0d", k), 32'(vch_log[k]), k);
    check("data_ch0", 32'(vdat_log[0]), 32'h000);
    check("data_ch1", 32'(vdat_log[1]), 32'hFFF);

    // First window: channel 1 full scale, channel 0 empty
    step_to(560);
    check("ch1_full", 32'(leds), 32'hFF);
    disp_ch = 3'd0;
    step_to(562);
    check("ch0_empty", 32'(leds), 32'h00);

    adc_val[0] = 12'd2300;
    adc_val[2] = 12'd1820;
    adc_val[3] = 12'hFFF;

    step_to(1040);
    disp_ch = 3'd2;
    step_to(1042);
    check("ch2_at_t3", 32'(leds), 32'h0F);
    disp_ch = 3'd5;
    step_to(1044);
    check("disp_oob", 32'(leds), 32'h1F);
    disp_ch = 3'd0;
    step_to(1046);
    check("ch0_level", 32'(leds), 32'h1F);

    adc_val[2] = 12'd1819;
    adc_val[3] = 12'd0;
    disp_ch  = 3'd3;
    dot_mode = 1'b1;
    step_to(1060);
    check("ch3_full_dot", 32'(leds), 32'hFF);

    disp_ch  = 3'd2;
    dot_mode = 1'b0;
    step_to(1542);
    check("ch2_below_t3", 32'(leds), 32'h07);

    // Display switch landing on channel 3's window end
    step_to(1568);
    disp_ch  = 3'd3;
    dot_mode = 1'b1;
    step_to(1569);
    check("win_edge_old", 32'(leds), 32'hFF);
    step_to(1570);
    check("win_edge_new", 32'(leds), 32'h80);

    // Held peak decays 64 per window; dot moves down below T[7]=3640
    for (int unsigned w = 3; w <= 11; w++) begin
      step_to(544 + 512 * w + 16);
      check($sformatf("decay_w%0d", w), 32'(leds), 32'(dot_exp[w - 3]));
    end

    disp_ch  = 3'd1;
    dot_mode = 1'b0;
    step_to(6200);
    check("pre_reset", 32'(leds), 32'hFF);

    // Reset asserted just after the SCLK falling edge opening bit 9
    step_to(6227);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(adc_cs_n), 32'h1);
    check("mid_rst_sclk", 32'(adc_sclk), 32'h1);
    check("mid_rst_leds", 32'(leds),     32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    adr_n = 0;
    val_n = 0;
    rst_n = 1'b1;
    cyc   = 0;

    step_to(40);
    check("post_rst_valid", val_n, 0);
    check("post_rst_addrn", adr_n, 1);
    check("post_rst_addr0", 32'(adr_log[0]), 32'h0);
    step_to(200);
    check("post_rst_leds", 32'(leds), 32'h00);
    check("saddr_idle_bits", bad_saddr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
